// File: rtl/fir_err_monitor.sv
// Error-statistics monitor for an approximate-adder FIR: compares approx against
// exact over a window of N samples and reports sum/max/mismatch statistics.
module fir_err_monitor #(
    parameter int W     = 16,
    parameter int N     = 256,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     approx,
    input  logic [W-1:0]     exact,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sample_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [W-1:0]     err_max,
    output logic [15:0]      max_idx,
    output logic [15:0]      mism_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sum is formed one bit wider than the wider operand so saturation can be detected.
    localparam int SUM_W = ((ACC_W > W) ? ACC_W : W) + 1;
    localparam logic [15:0]      LAST_IDX = 16'(N - 1);
    localparam logic [SUM_W-1:0] SAT_MAX  = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [15:0]      sample_cnt_reg;
    logic [ACC_W-1:0] err_sum_reg;
    logic [W-1:0]     err_max_reg;
    logic [15:0]      max_idx_reg;
    logic [15:0]      mism_cnt_reg;

    logic [W-1:0]     abs_err;
    logic [SUM_W-1:0] sum_wide;
    logic [ACC_W-1:0] err_sum_next;
    logic             new_max;
    logic             last_sample;

    always_comb begin
        abs_err      = '0;
        sum_wide     = '0;
        err_sum_next = '0;
        new_max      = 1'b0;
        last_sample  = 1'b0;

        abs_err  = (approx >= exact) ? (approx - exact) : (exact - approx);
        sum_wide = SUM_W'(err_sum_reg) + SUM_W'(abs_err);
        if (sum_wide > SAT_MAX) begin
            err_sum_next = {ACC_W{1'b1}};
        end else begin
            err_sum_next = sum_wide[ACC_W-1:0];
        end
        // Strict compare keeps the earliest index on ties.
        new_max     = (abs_err > err_max_reg);
        last_sample = (sample_cnt_reg == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            sample_cnt_reg <= '0;
            err_sum_reg    <= '0;
            err_max_reg    <= '0;
            max_idx_reg    <= '0;
            mism_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // A sample presented alongside start is not part of the new window.
                    if (start) begin
                        state_reg      <= RUN;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        sample_cnt_reg <= '0;
                        err_sum_reg    <= '0;
                        err_max_reg    <= '0;
                        max_idx_reg    <= '0;
                        mism_cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        sample_cnt_reg <= sample_cnt_reg + 16'd1;
                        err_sum_reg    <= err_sum_next;
                        if (abs_err != '0) begin
                            mism_cnt_reg <= mism_cnt_reg + 16'd1;
                        end
                        if (new_max) begin
                            err_max_reg <= abs_err;
                            max_idx_reg <= sample_cnt_reg;
                        end
                        if (last_sample) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign sample_cnt = sample_cnt_reg;
    assign err_sum    = err_sum_reg;
    assign err_max    = err_max_reg;
    assign max_idx    = max_idx_reg;
    assign mism_cnt   = mism_cnt_reg;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed bench for fir_err_monitor: N=4 window, plus an ACC_W=8 copy driven
// by the same stimulus to exercise err_sum saturation.
module tb_fir_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] approx;
    logic [15:0] exact;

    logic        busy, done;
    logic [15:0] sample_cnt, max_idx, mism_cnt, err_max;
    logic [31:0] err_sum;

    logic        busy8, done8;
    logic [15:0] sample_cnt8, max_idx8, mism_cnt8, err_max8;
    logic [7:0]  err_sum8;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    fir_err_monitor #(.W(16), .N(4), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .approx(approx), .exact(exact), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_sum(err_sum), .err_max(err_max),
        .max_idx(max_idx), .mism_cnt(mism_cnt)
    );

    fir_err_monitor #(.W(16), .N(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .approx(approx), .exact(exact), .busy(busy8), .done(done8),
        .sample_cnt(sample_cnt8), .err_sum(err_sum8), .err_max(err_max8),
        .max_idx(max_idx8), .mism_cnt(mism_cnt8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-22s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] e);
        in_valid = 1'b1;
        approx   = a;
        exact    = e;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; approx = '0; exact = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_sum", err_sum, 0);
        check("rst_max", err_max, 0);
        rst = 1'b0;
        tick();

        // Basic window: errors 0,5,17,0
        pulse_start();
        check("w1_busy", busy, 1);
        check("w1_cnt0", sample_cnt, 0);
        send(16'd10, 16'd10);
        check("w1_cnt1", sample_cnt, 1);
        send(16'd7, 16'd12);
        check("w1_sum2", err_sum, 5);
        send(16'd20, 16'd3);
        check("w1_done_early", done, 0);
        send(16'd5, 16'd5);
        check("w1_done", done, 1);
        check("w1_busy_lo", busy, 0);
        check("w1_sum", err_sum, 22);
        check("w1_max", err_max, 17);
        check("w1_idx", max_idx, 2);
        check("w1_mism", mism_cnt, 2);
        check("w1_cnt", sample_cnt, 4);
        check("w1_sum8", err_sum8, 22);

        // in_valid in DONE is ignored
        send(16'd100, 16'd0);
        check("done_ign_cnt", sample_cnt, 4);
        check("done_ign_sum", err_sum, 22);
        check("done_hold", done, 1);

        // start in DONE clears and re-arms; errors 3,9,9,1 with gaps
        pulse_start();
        check("rearm_busy", busy, 1);
        check("rearm_done", done, 0);
        check("rearm_sum", err_sum, 0);
        check("rearm_cnt", sample_cnt, 0);
        send(16'd3, 16'd0);
        tick();
        tick();
        check("gap_cnt", sample_cnt, 1);
        send(16'd0, 16'd9);
        tick();
        pulse_start();
        check("run_start_cnt", sample_cnt, 2);
        check("run_start_busy", busy, 1);
        send(16'd9, 16'd0);
        tick();
        send(16'd4, 16'd5);
        check("w2_done", done, 1);
        check("w2_max", err_max, 9);
        check("w2_idx", max_idx, 1);
        check("w2_sum", err_sum, 22);
        check("w2_cnt", sample_cnt, 4);
        check("w2_mism", mism_cnt, 4);

        // Reset mid-window discards the partial window
        pulse_start();
        send(16'd50, 16'd0);
        send(16'd0, 16'd30);
        check("mid_sum", err_sum, 80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_sum", err_sum, 0);
        check("mrst_cnt", sample_cnt, 0);
        check("mrst_max", err_max, 0);
        check("mrst_mism", mism_cnt, 0);

        // in_valid in IDLE ignored, including with start
        send(16'd5, 16'd0);
        check("idle_ign_cnt", sample_cnt, 0);
        check("idle_ign_busy", busy, 0);
        start = 1'b1;
        send(16'd7, 16'd0);
        start = 1'b0;
        check("start_iv_cnt", sample_cnt, 0);
        check("start_iv_sum", err_sum, 0);
        check("start_iv_busy", busy, 1);

        // Four errors of 100: 400 wide, saturates at 255 in the 8-bit copy
        send(16'd100, 16'd0);
        send(16'd0, 16'd100);
        send(16'd200, 16'd100);
        check("sat_done_early", done, 0);
        send(16'd150, 16'd250);
        check("sat_done", done, 1);
        check("sat_sum32", err_sum, 400);
        check("sat_sum8", err_sum8, 255);
        check("sat_mism8", mism_cnt8, 4);
        check("sat_mism", mism_cnt, 4);
        check("sat_max", err_max, 100);
        check("sat_idx", max_idx, 0);

        // Full-scale errors in both directions
        pulse_start();
        send(16'hFFFF, 16'h0000);
        send(16'h0000, 16'hFFFF);
        send(16'd0, 16'd0);
        send(16'd0, 16'd0);
        check("fs_done", done, 1);
        check("fs_max", err_max, 65535);
        check("fs_idx", max_idx, 0);
        check("fs_sum", err_sum, 131070);
        check("fs_mism", mism_cnt, 2);
        check("fs_sum8", err_sum8, 255);
        check("fs_max8", err_max8, 65535);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
